spi_flash_reader: RTL and testbench

- SPI mode-0 read initiator driving the external flash pins: flash_csb, flash_clk, flash_io0_do/oeb, flash_io1_di.
- Takes a single read request (24-bit address, 1–256 bytes), issues the standard READ (0x03) sequence and streams the returned bytes out on a valid/ready byte interface.
- It is the initiating end of the same link served by the spiflash simulation model.
- Used for boot-time or DMA-style bulk fetch of flash contents into the management SoC.

---
 rtl/spi_flash_reader_if.sv | 27 ++
 rtl/spi_flash_reader.sv | 258 +++++++++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if
//   Groups the request channel and the received-byte stream of the SPI flash reader.
//   Request: req_valid/req_ready handshake carrying req_addr (24-bit byte address)
//            and req_len (byte count minus one).
//   Stream:  rd_valid/rd_ready handshake carrying rd_data (one byte) and rd_last.
//   Modports: slave  - the reader block (accepts requests, produces bytes)
//             master - the requesting/consuming side
interface spi_flash_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic [7:0]  req_len;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_last;

    modport slave (
        input  req_valid, req_addr, req_len, rd_ready,
        output req_ready, rd_valid, rd_data, rd_last
    );

    modport master (
        output req_valid, req_addr, req_len, rd_ready,
        input  req_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   SPI mode-0 read initiator. Accepts one read request (address + length),
//   issues READ (0x03), or FAST_READ (0x0B) with 8 dummy clocks when the macro
//   FLASH_FAST_READ_EN is defined, and streams the returned bytes out.
// Ports:
//   sys_clk, sys_rst    clock, synchronous active-high reset
//   bus (slave)         request handshake and received-byte stream
//   busy                transaction in progress (csb low or recovery)
//   flash_csb           chip select, active-low
//   flash_clk           SPI clock, idles low, each level CLK_DIV sys_clk cycles
//   flash_io0_do/oeb    MOSI and its active-low output enable
//   flash_io1_di        MISO, sampled on the sys_clk edge that raises flash_clk
// Parameters:
//   CLK_DIV   sys_clk cycles per flash_clk half-period (1..255)
//   CSB_HIGH  minimum sys_clk cycles csb stays high between transactions (1..255)
module spi_flash_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CSB_HIGH = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    spi_flash_reader_if.slave       bus,
    output logic                    busy,
    output logic                    flash_csb,
    output logic                    flash_clk,
    output logic                    flash_io0_do,
    output logic                    flash_io0_oeb,
    input  logic                    flash_io1_di
);

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE = 8'h0B;
`else
    localparam logic [7:0] CMD_BYTE = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef FLASH_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_STALL,
        S_RECOVER
    } state_t;

    state_t      r_state, w_state;
    logic [7:0]  r_div,   w_div;
    logic [4:0]  r_bit,   w_bit;
    logic [31:0] r_tx,    w_tx;
    logic [7:0]  r_rx,    w_rx;
    logic [8:0]  r_bytes, w_bytes;
    logic [7:0]  r_len,   w_len;
    logic        r_fin,   w_fin;
    logic [7:0]  r_rcnt,  w_rcnt;
    logic        r_csb,   w_csb;
    logic        r_clk,   w_clk;
    logic        r_io0,   w_io0;
    logic        r_oeb,   w_oeb;
    logic        r_rd_valid, w_rd_valid;
    logic [7:0]  r_rd_data,  w_rd_data;
    logic        r_rd_last,  w_rd_last;

    logic        w_req_ready;
    logic        w_div_term;
    logic [7:0]  w_rx_byte;

    assign w_req_ready = (r_state == S_IDLE) && !sys_rst;
    assign w_div_term  = (r_div == 8'(CLK_DIV - 1));
    assign w_rx_byte   = {r_rx[6:0], flash_io1_di};

    always_comb begin
        w_state    = r_state;
        w_div      = r_div;
        w_bit      = r_bit;
        w_tx       = r_tx;
        w_rx       = r_rx;
        w_bytes    = r_bytes;
        w_len      = r_len;
        w_fin      = r_fin;
        w_rcnt     = r_rcnt;
        w_csb      = r_csb;
        w_clk      = r_clk;
        w_io0      = r_io0;
        w_oeb      = r_oeb;
        w_rd_valid = r_rd_valid;
        w_rd_data  = r_rd_data;
        w_rd_last  = r_rd_last;

        // Consumer acceptance; a byte completing this same cycle overrides below.
        if (r_rd_valid && bus.rd_ready) begin
            w_rd_valid = 1'b0;
            w_rd_last  = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_state = S_CMD;
                    w_csb   = 1'b0;
                    w_oeb   = 1'b0;
                    w_clk   = 1'b0;
                    w_io0   = CMD_BYTE[7];
                    w_tx    = {CMD_BYTE, bus.req_addr};
                    w_len   = bus.req_len;
                    w_div   = '0;
                    w_bit   = '0;
                    w_bytes = '0;
                    w_fin   = 1'b0;
                end
            end

            S_CMD, S_ADDR
`ifdef FLASH_FAST_READ_EN
            , S_DUMMY
`endif
            : begin
                if (!w_div_term) begin
                    w_div = r_div + 8'd1;
                end else begin
                    w_div = '0;
                    w_clk = ~r_clk;
                    if (r_clk) begin
                        // Falling point: present the next outgoing bit.
                        w_bit = r_bit + 5'd1;
                        w_tx  = r_tx << 1;
                        w_io0 = r_tx[30];
                        if (r_state == S_CMD && r_bit == 5'd7) begin
                            w_state = S_ADDR;
                            w_bit   = '0;
                        end else if (r_state == S_ADDR && r_bit == 5'd23) begin
`ifdef FLASH_FAST_READ_EN
                            w_state = S_DUMMY;
`else
                            w_state = S_DATA;
`endif
                            w_bit = '0;
                            w_oeb = 1'b1;
                            w_io0 = 1'b0;
                        end
`ifdef FLASH_FAST_READ_EN
                        if (r_state == S_DUMMY) begin
                            w_io0 = 1'b0;
                            if (r_bit == 5'd7) begin
                                w_state = S_DATA;
                                w_bit   = '0;
                            end
                        end
`endif
                    end
                end
            end

            S_DATA: begin
                if (!w_div_term) begin
                    w_div = r_div + 8'd1;
                end else if (!r_clk) begin
                    // Rising point. Hold clk low instead if this edge would
                    // complete a byte while the previous one is still unread.
                    if (r_bit == 5'd7 && r_rd_valid && !bus.rd_ready) begin
                        w_state = S_STALL;
                    end else begin
                        w_div = '0;
                        w_clk = 1'b1;
                        w_rx  = w_rx_byte;
                        w_bit = r_bit + 5'd1;
                        if (r_bit == 5'd7) begin
                            w_bit      = '0;
                            w_rd_valid = 1'b1;
                            w_rd_data  = w_rx_byte;
                            w_rd_last  = (r_bytes == {1'b0, r_len});
                            w_fin      = (r_bytes == {1'b0, r_len});
                            w_bytes    = r_bytes + 9'd1;
                        end
                    end
                end else begin
                    w_div = '0;
                    w_clk = 1'b0;
                    if (r_fin) begin
                        w_state = S_RECOVER;
                        w_csb   = 1'b1;
                        w_rcnt  = '0;
                    end
                end
            end

            S_STALL: begin
                // Restart the low-level count at acceptance so clocking resumes
                // CLK_DIV cycles later.
                if (bus.rd_ready) begin
                    w_state = S_DATA;
                    w_div   = '0;
                end
            end

            S_RECOVER: begin
                if (r_rcnt != 8'(CSB_HIGH - 1)) begin
                    w_rcnt = r_rcnt + 8'd1;
                end else if (!r_rd_valid || bus.rd_ready) begin
                    w_state = S_IDLE;
                end
            end

            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bytes    <= '0;
            r_len      <= '0;
            r_fin      <= 1'b0;
            r_rcnt     <= '0;
            r_csb      <= 1'b1;
            r_clk      <= 1'b0;
            r_io0      <= 1'b0;
            r_oeb      <= 1'b1;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_div      <= w_div;
            r_bit      <= w_bit;
            r_tx       <= w_tx;
            r_rx       <= w_rx;
            r_bytes    <= w_bytes;
            r_len      <= w_len;
            r_fin      <= w_fin;
            r_rcnt     <= w_rcnt;
            r_csb      <= w_csb;
            r_clk      <= w_clk;
            r_io0      <= w_io0;
            r_oeb      <= w_oeb;
            r_rd_valid <= w_rd_valid;
            r_rd_data  <= w_rd_data;
            r_rd_last  <= w_rd_last;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_last    = r_rd_last;
    assign busy           = !w_req_ready && !sys_rst;
    assign flash_csb      = r_csb;
    assign flash_clk      = r_clk;
    assign flash_io0_do   = r_io0;
    assign flash_io0_oeb  = r_oeb;

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader
//   Directed bench for spi_flash_reader with a behavioural SPI flash on the pins.
//   Table of read requests plus hand-written reset and back-to-back sequences.
module tb_spi_flash_reader;
    localparam int CLK_DIV  = 2;
    localparam int CSB_HIGH = 4;
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] EXP_CMD = 8'h0B;
    localparam int         HDR     = 40;
`else
    localparam logic [7:0] EXP_CMD = 8'h03;
    localparam int         HDR     = 32;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic busy, csb, fclk, io0, oeb;
    logic miso = 1'b0;

    spi_flash_reader_if bif();

    spi_flash_reader #(.CLK_DIV(CLK_DIV), .CSB_HIGH(CSB_HIGH)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .bus           (bif),
        .busy          (busy),
        .flash_csb     (csb),
        .flash_clk     (fclk),
        .flash_io0_do  (io0),
        .flash_io0_oeb (oeb),
        .flash_io1_di  (miso)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int min);
        n_checks++;
        if (act < min) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
        end
    endtask

    // Flash contents: a few fixed words, a simple pattern elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h100000: return 8'h6F;
            24'h100001: return 8'h00;
            24'h100002: return 8'h00;
            24'h100003: return 8'h13;
            default:    return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    // ---------------- behavioural SPI flash ----------------
    int          m_rise = 0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    int          m_oeb_err = 0;

    always @(negedge csb) begin
        m_rise = 0;
        m_cmd  = '0;
        m_addr = '0;
    end

    always @(posedge fclk) begin
        if (!csb) begin
            if (m_rise < 8) begin
                m_cmd = {m_cmd[6:0], io0};
                if (oeb) m_oeb_err++;
            end else if (m_rise < 32) begin
                m_addr = {m_addr[22:0], io0};
                if (oeb) m_oeb_err++;
            end else if (m_rise < HDR) begin
                if (!oeb || io0) m_oeb_err++;
            end else if (!oeb) begin
                m_oeb_err++;
            end
            m_rise++;
        end
    end

    always @(negedge fclk) begin
        if (!csb && m_rise >= HDR) begin
            int         idx;
            logic [7:0] b;
            idx  = m_rise - HDR;
            b    = flash_byte(m_addr + 24'(idx / 8));
            miso = b[7 - (idx % 8)];
        end
    end

    // ---------------- negedge monitor / consumer ----------------
    logic [8:0] rx_q[$];
    int         hi_runs[$];
    int         lo_runs[$];
    int stall_after = 0;
    int stall_len   = 0;
    int stall_cnt   = 0;
    int n_accept    = 0;
    int run         = 0;
    int csb_hi_run  = 0;
    int last_gap    = 0;
    logic prev_clk  = 1'b0;

    always @(negedge sys_clk) begin
        if (stall_cnt > 0) begin
            bif.rd_ready = 1'b0;
            stall_cnt--;
        end else begin
            bif.rd_ready = 1'b1;
        end
        if (bif.rd_valid && bif.rd_ready) begin
            rx_q.push_back({bif.rd_last, bif.rd_data});
            if (rx_q.size() == stall_after) stall_cnt = stall_len;
        end
        if (bif.req_valid && bif.req_ready) n_accept++;
        if (csb) begin
            csb_hi_run++;
        end else begin
            if (csb_hi_run != 0) last_gap = csb_hi_run;
            csb_hi_run = 0;
        end
        if (!csb) begin
            if (fclk !== prev_clk) begin
                if (prev_clk) hi_runs.push_back(run);
                else          lo_runs.push_back(run);
                run = 1;
            end else begin
                run++;
            end
        end else begin
            run = 0;
        end
        prev_clk = fclk;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [23:0] addr;
        logic [7:0]  len;
        int          stall_at;    // stall after this many bytes accepted (0 = none)
        int          stall_len;   // cycles rd_ready is held low
        logic [7:0]  exp_first;   // hand-computed first byte
        int          exp_clocks;  // total SPI clocks for the transaction
    } vec_t;

    vec_t vecs[5];

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int base_rx, input int nb, input string tag);
        int cyc;
        cyc = 0;
        while (!((rx_q.size() >= base_rx + nb) && bif.req_ready) && cyc < 20000) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        if (cyc >= 20000) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: got %0d bytes, expected %0d", tag, rx_q.size() - base_rx, nb);
        end
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int base_rx, base_hi, base_lo, base_oeb, nb, cyc, bad_hi, bad_lo;
        logic [8:0] exp;
        base_rx  = rx_q.size();
        base_hi  = hi_runs.size();
        base_lo  = lo_runs.size();
        base_oeb = m_oeb_err;
        nb       = int'(v.len) + 1;
        stall_after = (v.stall_at > 0) ? base_rx + v.stall_at : 0;
        stall_len   = v.stall_len;
        cyc = 0;
        while (!bif.req_ready && cyc < 1000) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        bif.req_addr  = v.addr;
        bif.req_len   = v.len;
        bif.req_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bif.req_valid = 1'b0;
        check($sformatf("v%0d req_ready after accept", k), bif.req_ready, 1'b0);
        check($sformatf("v%0d busy after accept", k), busy, 1'b1);
        check($sformatf("v%0d csb after accept", k), csb, 1'b0);
        wait_idle(base_rx, nb, $sformatf("v%0d", k));
        check($sformatf("v%0d command", k), m_cmd, EXP_CMD);
        check($sformatf("v%0d address", k), m_addr, v.addr);
        check($sformatf("v%0d spi clocks", k), m_rise, v.exp_clocks);
        check($sformatf("v%0d oeb/io0 errors", k), m_oeb_err - base_oeb, 0);
        check($sformatf("v%0d byte count", k), rx_q.size() - base_rx, nb);
        if (rx_q.size() > base_rx)
            check($sformatf("v%0d first byte", k), rx_q[base_rx][7:0], v.exp_first);
        for (int i = 0; i < nb; i++) begin
            exp = {(i == nb - 1), flash_byte(v.addr + 24'(i))};
            if (base_rx + i < rx_q.size())
                check($sformatf("v%0d byte %0d {last,data}", k, i), rx_q[base_rx + i], exp);
        end
        bad_hi = 0;
        bad_lo = 0;
        for (int i = base_hi; i < hi_runs.size(); i++) if (hi_runs[i] != CLK_DIV) bad_hi++;
        for (int i = base_lo; i < lo_runs.size(); i++) if (lo_runs[i] != CLK_DIV) bad_lo++;
        check($sformatf("v%0d clk high runs != CLK_DIV", k), bad_hi, 0);
        if (v.stall_len == 0)
            check($sformatf("v%0d clk low runs != CLK_DIV", k), bad_lo, 0);
        stall_after = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rx, base_acc, cyc;

        vecs[0] = '{24'h100000, 8'd3,   0, 0,  8'h6F, HDR + 32};
        vecs[1] = '{24'h100000, 8'd3,   1, 50, 8'h6F, HDR + 32};
        vecs[2] = '{24'h000000, 8'd0,   0, 0,  8'h5A, HDR + 8};
        vecs[3] = '{24'h012300, 8'd255, 0, 0,  8'h79, HDR + 2048};
        vecs[4] = '{24'hABCDEF, 8'd7,   7, 60, 8'h78, HDR + 64};

        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_len   = '0;

        // Reset values
        wait_cycles(4);
        check("reset outputs {csb,clk,io0,oeb,req_ready,busy,rd_valid,rd_last}",
              {csb, fclk, io0, oeb, bif.req_ready, busy, bif.rd_valid, bif.rd_last}, 8'b1001_0000);
        check("reset rd_data", bif.rd_data, 8'h00);
        sys_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            check($sformatf("idle %0d {csb,clk,oeb,req_ready,rd_valid,busy}", i),
                  {csb, fclk, oeb, bif.req_ready, bif.rd_valid, busy}, 6'b101100);
        end

        for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

        // Single-byte request immediately followed by a second one held pending.
        base_rx  = rx_q.size();
        base_acc = n_accept;
        bif.req_addr  = 24'h000040;
        bif.req_len   = 8'd0;
        bif.req_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bif.req_addr = 24'h000081;
        cyc = 0;
        while (n_accept < base_acc + 2 && cyc < 2000) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        bif.req_valid = 1'b0;
        check("b2b accepts", n_accept - base_acc, 2);
        wait_idle(base_rx, 2, "b2b");
        check_ge("b2b csb high gap", last_gap, CSB_HIGH);
        check("b2b second spi clocks", m_rise, HDR + 8);
        check("b2b second address", m_addr, 24'h000081);
        if (rx_q.size() >= base_rx + 2) begin
            check("b2b byte 0 {last,data}", rx_q[base_rx], {1'b1, flash_byte(24'h000040)});
            check("b2b byte 1 {last,data}", rx_q[base_rx + 1], {1'b1, flash_byte(24'h000081)});
        end

        // Reset pulse in the middle of the address phase.
        base_rx = rx_q.size();
        bif.req_addr  = 24'h100000;
        bif.req_len   = 8'd3;
        bif.req_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        bif.req_valid = 1'b0;
        cyc = 0;
        while (m_rise < 16 && cyc < 1000) begin
            @(posedge sys_clk);
            #1;
            cyc++;
        end
        check("mid-addr busy", busy, 1'b1);
        check("mid-addr csb", csb, 1'b0);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("reset mid-addr {csb,clk,oeb,rd_valid,req_ready,busy}",
              {csb, fclk, oeb, bif.rd_valid, bif.req_ready, busy}, 6'b101000);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("after reset {req_ready,busy,csb}", {bif.req_ready, busy, csb}, 3'b101);
        wait_cycles(10);
        check("after reset no bytes delivered", rx_q.size() - base_rx, 0);
        check("after reset still idle {csb,clk}", {csb, fclk}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
